// File: rtl/edge_pixel_writer.sv
// edge_pixel_writer: last stage of the Canny pipeline. Turns the 1-bit
// hysteresis decision stream into one byte per pixel for the write SRAM.
// It generates a linear write address, requests a memory dump once the
// frame is complete, and keeps a sticky protocol-error flag.
// Optional feature: define EDGE_BORDER_MASK_EN to force border pixels to 8'h00.
module edge_pixel_writer #(
    parameter int         IMG_W       = 512,
    parameter int         IMG_H       = 512,
    parameter int         ADDR_W      = 18,
    parameter logic [7:0] EDGE_VAL    = 8'hFF,
    parameter int         DUMP_CYCLES = 2,
    parameter int         BORDER      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pixel_valid,
    input  logic              hysteresis_result,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [7:0]        write_data,
    output logic              file_dump,
    output logic              frame_done,
    output logic              busy,
    output logic              error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam int                DCNT_W    = $clog2(DUMP_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DUMP_LAST = DCNT_W'(DUMP_CYCLES);

    // Reject configurations the addressing and dump sequencing cannot support.
    if (IMG_W * IMG_H != 2 ** ADDR_W || DUMP_CYCLES < 1 || 2 * BORDER > IMG_W
        || 2 * BORDER > IMG_H) begin : g_bad_cfg
        $error("edge_pixel_writer: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DUMP   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DCNT_W-1:0]   dump_cnt, dump_cnt_nxt;
    logic [ADDR_W-1:0]   pix_cnt_p0;
    logic                accept_p0;
    logic                restart_p0;
    logic                err_set_p0;
    logic                in_border;

    // Byte written for one pixel; border-masked pixels never carry an edge.
    function automatic logic [7:0] pixel_byte(input logic is_edge, input logic masked);
        return (is_edge && !masked) ? EDGE_VAL : 8'h00;
    endfunction

    // State register plus dump-phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dump_cnt <= '0;
        end else begin
            state    <= state_nxt;
            dump_cnt <= dump_cnt_nxt;
        end
    end

    // Next-state decode, pixel acceptance and protocol-error detection.
    // DUMP spans the trailing write cycle (dump_cnt == 0) followed by
    // DUMP_CYCLES cycles of file_dump, so the dump never overlaps a write.
    always_comb begin
        state_nxt    = state;
        dump_cnt_nxt = dump_cnt;
        accept_p0    = 1'b0;
        restart_p0   = 1'b0;
        err_set_p0   = 1'b0;
        case (state)
            IDLE: begin
                if (pixel_valid) err_set_p0 = 1'b1;
                if (start) begin
                    restart_p0 = 1'b1;
                    state_nxt  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (start) begin
                    // Abort and restart at address 0; a coincident pixel is dropped.
                    restart_p0 = 1'b1;
                    err_set_p0 = 1'b1;
                end else if (pixel_valid) begin
                    accept_p0 = 1'b1;
                    if (pix_cnt_p0 == LAST_ADDR) begin
                        state_nxt    = DUMP;
                        dump_cnt_nxt = '0;
                    end
                end
            end
            DUMP: begin
                if (start || pixel_valid) err_set_p0 = 1'b1;
                if (dump_cnt == DUMP_LAST) begin
                    state_nxt    = IDLE;
                    dump_cnt_nxt = '0;
                end else begin
                    dump_cnt_nxt = dump_cnt + DCNT_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                dump_cnt_nxt = '0;
            end
        endcase
    end

    // Linear pixel counter; restart returns it to the first pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_p0 <= '0;
        end else if (restart_p0) begin
            pix_cnt_p0 <= '0;
        end else if (accept_p0) begin
            pix_cnt_p0 <= pix_cnt_p0 + ADDR_W'(1);
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error <= 1'b0;
        end else if (err_set_p0) begin
            error <= 1'b1;
        end
    end

`ifdef EDGE_BORDER_MASK_EN
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    logic [ROW_W-1:0] row_p0;
    logic [COL_W-1:0] col_p0;

    // Row/column position tracking the linear counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= '0;
            col_p0 <= '0;
        end else if (restart_p0) begin
            row_p0 <= '0;
            col_p0 <= '0;
        end else if (accept_p0) begin
            if (col_p0 == COL_W'(IMG_W - 1)) begin
                col_p0 <= '0;
                row_p0 <= row_p0 + ROW_W'(1);
            end else begin
                col_p0 <= col_p0 + COL_W'(1);
            end
        end
    end

    // Pixel lies inside the masked frame border.
    always_comb begin
        in_border = (row_p0 <  ROW_W'(BORDER))
                 || (row_p0 >= ROW_W'(IMG_H - BORDER))
                 || (col_p0 <  COL_W'(BORDER))
                 || (col_p0 >= COL_W'(IMG_W - BORDER));
    end
`else
    assign in_border = 1'b0;
`endif

    // ---- stage p0 -> p1: accepted pixel becomes an SRAM write next cycle ----
    // Address and data hold between writes; only the strobe drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= 8'h00;
        end else begin
            write_enable <= accept_p0;
            if (accept_p0) begin
                write_address <= pix_cnt_p0;
                write_data    <= pixel_byte(hysteresis_result, in_border);
            end
        end
    end

    assign file_dump  = (state == DUMP) && (dump_cnt != '0);
    assign frame_done = (state == DUMP) && (dump_cnt == DUMP_LAST);
    assign busy       = (state != IDLE);

endmodule
